// File: rtl/shift_rows_pipe.sv
// Two-stage pipelined Rijndael ShiftRows / InvShiftRows for 4, 6 or 8 column states.
// Define SHIFT_ROWS_PIPE_INV_EN to honour in_inv; otherwise every state is forward-shifted.
module shift_rows_pipe #(
  parameter int NB    = 4,
  parameter int W     = 32 * NB,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_inv,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [W-1:0]     in_state,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic [W-1:0]     out_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // a presented output (state + tag) holds until out_ready; in_ready is low during flush.

  generate
    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
      $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end
    if (W != 32 * NB) begin : g_bad_w
      $error("shift_rows_pipe: W is derived from NB and must not be overridden");
    end
    if (TAG_W < 1 || TAG_W > 16) begin : g_bad_tag
      $error("shift_rows_pipe: TAG_W must be in 1..16");
    end
  endgenerate

  // Wide blocks move rows 2 and 3 one column further than narrow ones.
  function automatic int row_offset(input int r);
    return (NB == 8 && r >= 2) ? r + 1 : r;
  endfunction

  logic             s1_v;
  logic [W-1:0]     s1_state;
  logic [TAG_W-1:0] s1_tag;
  logic             s2_v;
  logic [W-1:0]     s2_state;
  logic [TAG_W-1:0] s2_tag;

  logic             adv1;
  logic             adv2;
  logic [W-1:0]     fwd_state;
  logic [W-1:0]     shifted;

  assign adv2     = !s2_v || out_ready;
  assign adv1     = !s1_v || adv2;
  assign in_ready = adv1 && !flush;

  always_comb begin
    fwd_state = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < NB; c++) begin
        fwd_state[W-1-8*(r+4*c) -: 8] =
          s1_state[W-1-8*(r+4*((c + row_offset(r)) % NB)) -: 8];
      end
    end
  end

`ifdef SHIFT_ROWS_PIPE_INV_EN
  logic         s1_inv;
  logic [W-1:0] inv_state;

  always_comb begin
    inv_state = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < NB; c++) begin
        inv_state[W-1-8*(r+4*c) -: 8] =
          s1_state[W-1-8*(r+4*((c + NB - row_offset(r)) % NB)) -: 8];
      end
    end
  end

  assign shifted = s1_inv ? inv_state : fwd_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_inv <= 1'b0;
    end else if (!flush && adv1 && in_valid) begin
      s1_inv <= in_inv;
    end
  end
`else
  logic in_inv_unused;

  assign in_inv_unused = in_inv;
  assign shifted       = fwd_state;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v     <= 1'b0;
      s1_state <= '0;
      s1_tag   <= '0;
      s2_v     <= 1'b0;
      s2_state <= '0;
      s2_tag   <= '0;
    end else if (flush) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else begin
      if (adv2) begin
        s2_v <= s1_v;
        if (s1_v) begin
          s2_state <= shifted;
          s2_tag   <= s1_tag;
        end
      end
      if (adv1) begin
        s1_v <= in_valid;
        if (in_valid) begin
          s1_state <= in_state;
          s1_tag   <= in_tag;
        end
      end
    end
  end

  assign out_valid = s2_v;
  assign out_state = s2_state;
  assign out_tag   = s2_tag;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Bench for shift_rows_pipe: NB=4 scoreboard under random traffic plus directed NB=6/NB=8 checks.
module tb_shift_rows_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic         in_inv;
  logic [3:0]   in_tag;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   out_tag;
  logic [127:0] out_state;

  shift_rows_pipe #(.NB(4), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv),
    .in_tag(in_tag), .in_state(in_state),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_tag(out_tag), .out_state(out_state)
  );

  logic         side_flush = 1'b0;
  logic         side_ready = 1'b1;
  logic         side_inv   = 1'b0;
  logic [3:0]   side_tag   = 4'h5;

  logic         v6_in_valid;
  logic         v6_in_ready;
  logic [191:0] v6_in_state;
  logic         v6_out_valid;
  logic [3:0]   v6_out_tag;
  logic [191:0] v6_out_state;

  shift_rows_pipe #(.NB(6), .TAG_W(4)) dut6 (
    .clk(clk), .rst_n(rst_n), .flush(side_flush),
    .in_valid(v6_in_valid), .in_ready(v6_in_ready), .in_inv(side_inv),
    .in_tag(side_tag), .in_state(v6_in_state),
    .out_valid(v6_out_valid), .out_ready(side_ready),
    .out_tag(v6_out_tag), .out_state(v6_out_state)
  );

  logic         v8_in_valid;
  logic         v8_in_ready;
  logic [255:0] v8_in_state;
  logic         v8_out_valid;
  logic [3:0]   v8_out_tag;
  logic [255:0] v8_out_state;

  shift_rows_pipe #(.NB(8), .TAG_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .flush(side_flush),
    .in_valid(v8_in_valid), .in_ready(v8_in_ready), .in_inv(side_inv),
    .in_tag(side_tag), .in_state(v8_in_state),
    .out_valid(v8_out_valid), .out_ready(side_ready),
    .out_tag(v8_out_tag), .out_state(v8_out_state)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: each row is a queue of bytes rotated left (forward) or right (inverse).
  function automatic logic [255:0] model_shift(input logic [255:0] s, input int nb, input bit inv);
    logic [7:0]   row_q[$];
    logic [255:0] o;
    int           w;
    int           sh;
    o = '0;
    w = 32 * nb;
    for (int r = 0; r < 4; r++) begin
      row_q.delete();
      for (int c = 0; c < nb; c++) row_q.push_back(s[w-1-8*(r+4*c) -: 8]);
      sh = (nb == 8 && r >= 2) ? r + 1 : r;
      for (int i = 0; i < sh; i++) begin
        if (!inv) row_q.push_back(row_q.pop_front());
        else      row_q.push_front(row_q.pop_back());
      end
      for (int c = 0; c < nb; c++) o[w-1-8*(r+4*c) -: 8] = row_q[c];
    end
    return o;
  endfunction

  function automatic bit eff_inv(input bit inv);
`ifdef SHIFT_ROWS_PIPE_INV_EN
    return inv;
`else
    return 1'b0;
`endif
  endfunction

  // Scoreboard and monitor, sampling mid-cycle on the falling edge.
  logic [127:0] exp_q[$];
  logic [3:0]   tag_q[$];
  int           out_cnt = 0;
  int           cyc_cnt = 0;
  logic         hold_v  = 1'b0;
  logic [127:0] held_state;
  logic [3:0]   held_tag;

  always @(negedge clk) begin
    logic [255:0] m;
    cyc_cnt++;
    if (!rst_n) begin
      exp_q.delete();
      tag_q.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v && out_valid) begin
        check("hold_state", out_state, held_state);
        check("hold_tag", out_tag, held_tag);
      end
      hold_v     = out_valid && !out_ready;
      held_state = out_state;
      held_tag   = out_tag;
      if (out_valid && out_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          check("out_state", out_state, exp_q.pop_front());
          check("out_tag", out_tag, tag_q.pop_front());
        end
      end
      if (flush) begin
        exp_q.delete();
        tag_q.delete();
      end else if (in_valid && in_ready) begin
        m = model_shift({128'b0, in_state}, 4, eff_inv(in_inv));
        exp_q.push_back(m[127:0]);
        tag_q.push_back(in_tag);
      end
    end
  end

  // Driver tasks: inputs change 2 time units after the rising edge.
  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [127:0] s, input bit inv, input logic [3:0] t);
    in_valid = 1'b1;
    in_state = s;
    in_inv   = inv;
    in_tag   = t;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        cycle();
        in_valid = 1'b0;
        return;
      end
      cycle();
    end
    check("send_timeout", 1, 0);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) cycle();
    check("drain_empty", exp_q.size(), 0);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  localparam logic [127:0] FIPS_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
`ifdef SHIFT_ROWS_PIPE_INV_EN
  localparam logic [127:0] INV_EXP  = 128'hd42711aee0bf98f1b8b45de51e415230;
`else
  localparam logic [127:0] INV_EXP  = 128'hd4b411e5e0419830b8275dae1ebf52f1;
`endif

  initial begin
    int           lat;
    int           c0;
    int           k0;
    bit           seen_full;
    logic [191:0] s6;
    logic [255:0] s8;
    logic [255:0] m;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inv = 1'b0; in_tag = '0;
    in_state = '0; out_ready = 1'b1;
    v6_in_valid = 1'b0; v6_in_state = '0; v8_in_valid = 1'b0; v8_in_state = '0;
    repeat (3) cycle();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_state", out_state, 0);
    check("rst_out_tag", out_tag, 0);
    rst_n = 1'b1;
    cycle();
    check("rst_in_ready", in_ready, 1);

    // FIPS-197 forward vector and latency.
    send(FIPS_IN, 1'b0, 4'h3);
    lat = 1;
    for (int i = 0; i < 20 && !out_valid; i++) begin
      cycle();
      lat++;
    end
    check("fips_latency", lat, 2);
    check("fips_fwd_state", out_state, FIPS_OUT);
    check("fips_fwd_tag", out_tag, 4'h3);
    cycle();

    // Inverse request on the FIPS output.
    send(FIPS_OUT, 1'b1, 4'hc);
    for (int i = 0; i < 20 && !out_valid; i++) cycle();
    check("fips_inv_state", out_state, INV_EXP);
    check("fips_inv_tag", out_tag, 4'hc);
    drain();

    // Byte-index states for the wider block sizes.
    for (int k = 0; k < 24; k++) s6[191-8*k -: 8] = k[7:0];
    for (int k = 0; k < 32; k++) s8[255-8*k -: 8] = k[7:0];
    v6_in_state = s6; v8_in_state = s8;
    v6_in_valid = 1'b1; v8_in_valid = 1'b1;
    cycle();
    v6_in_valid = 1'b0; v8_in_valid = 1'b0;
    for (int i = 0; i < 20 && !(v6_out_valid && v8_out_valid); i++) cycle();
    check("nb6_valid", v6_out_valid, 1);
    check("nb6_col0", v6_out_state[191:160], 32'h00050a0f);
    m = model_shift({64'b0, s6}, 6, 1'b0);
    check("nb6_state", v6_out_state, m[191:0]);
    check("nb6_tag", v6_out_tag, 4'h5);
    check("nb8_valid", v8_out_valid, 1);
    check("nb8_col0", v8_out_state[255:224], 32'h00050e13);
    check("nb8_state", v8_out_state, model_shift(s8, 8, 1'b0));
    cycle();

    // Backpressure: tags 0..9 with out_ready low for cycles 3-6.
    c0 = out_cnt;
    seen_full = 1'b0;
    fork
      begin
        for (int t = 0; t < 10; t++) send(rand128(), $urandom_range(0, 1), t[3:0]);
      end
      begin
        for (int cyc = 0; cyc < 16; cyc++) begin
          out_ready = !(cyc >= 3 && cyc <= 6);
          @(negedge clk);
          if (!in_ready && !seen_full) begin
            seen_full = 1'b1;
            check("full_depth", exp_q.size(), 2);
            check("full_out_valid", out_valid, 1);
          end
          cycle();
        end
      end
    join
    check("full_seen", seen_full, 1);
    drain();
    check("bp_count", out_cnt - c0, 10);

    // Alternating direction, back-to-back.
    c0 = out_cnt;
    k0 = cyc_cnt;
    for (int i = 0; i < 8; i++) send(rand128(), i[0], i[3:0]);
    check("alt_accept_cycles", cyc_cnt - k0, 8);
    cycle();
    cycle();
    check("alt_out_count", out_cnt - c0, 8);
    drain();

    // Flush with two states in flight.
    out_ready = 1'b0;
    send(rand128(), 1'b0, 4'h1);
    send(rand128(), 1'b1, 4'h2);
    check("pre_flush_valid", out_valid, 1);
    flush = 1'b1;
    in_valid = 1'b1;
    in_state = rand128();
    in_tag = 4'h7;
    @(negedge clk);
    check("flush_in_ready", in_ready, 0);
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", out_valid, 0);
    c0 = out_cnt;
    out_ready = 1'b1;
    repeat (5) cycle();
    check("flush_no_output", out_cnt - c0, 0);

    // Asynchronous reset in the middle of a stall.
    out_ready = 1'b0;
    send(rand128(), 1'b0, 4'h8);
    send(rand128(), 1'b0, 4'h9);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_state", out_state, 0);
    check("async_rst_tag", out_tag, 0);
    #4 rst_n = 1'b1;
    #4;
    cycle();
    check("post_rst_in_ready", in_ready, 1);
    out_ready = 1'b1;

    // Random traffic with random stalls and occasional flushes.
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      in_inv    = $urandom_range(0, 1);
      in_tag    = 4'($urandom_range(0, 15));
      in_state  = rand128();
      cycle();
    end
    drain();
    cycle();
    check("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
